// File: rtl/datapath_pkg.sv
// Shared constants for the datapath steering blocks.
package datapath_pkg;

    // Channel encodings carried on the select line
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    // Default widths for the steering unit
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/demux_chan_reg.sv
// Single-entry output buffer for one steering channel, with a wrapping
// count of words handed to the consumer.
module demux_chan_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_can_accept
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              drain;

    assign drain = valid_q & i_ready;

    // Space is available when empty or when the held word leaves this cycle
    assign o_can_accept = ~valid_q | i_ready;

    // Next-state: a load in the same cycle as a drain keeps valid high
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        if (drain) begin
            valid_d = 1'b0;
            count_d = count_q + 1'b1;
        end
        if (i_load) begin
            data_d  = i_data;
            valid_d = 1'b1;
        end
    end

    // Buffer and counter state; reset discards any held word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_count = count_q;

endmodule

// File: rtl/demux32bit_1bitselect_buf.sv
// Registered 1-to-2 steering unit: routes each accepted word to channel A
// or B, each with its own single-entry buffer and independent back-pressure.
module demux32bit_1bitselect_buf
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_select,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_A_data,
    output logic              o_A_valid,
    input  logic              i_A_ready,
    output logic [DATA_W-1:0] o_B_data,
    output logic              o_B_valid,
    input  logic              i_B_ready,
    output logic [CNT_W-1:0]  o_A_count,
    output logic [CNT_W-1:0]  o_B_count
);

    logic sel_a;
    logic sel_b;
    logic a_can_accept;
    logic b_can_accept;
    logic accept;
    logic load_a;
    logic load_b;

    // Select decode, ready mux and load enables; ready never looks at i_valid
    always_comb begin
        sel_a   = (i_select == CH_A);
        sel_b   = (i_select == CH_B);
        o_ready = sel_b ? b_can_accept : a_can_accept;
        accept  = i_valid & o_ready;
        load_a  = accept & sel_a;
        load_b  = accept & sel_b;
    end

    demux_chan_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_chan_a (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (load_a),
        .i_data       (i_data),
        .i_ready      (i_A_ready),
        .o_data       (o_A_data),
        .o_valid      (o_A_valid),
        .o_count      (o_A_count),
        .o_can_accept (a_can_accept)
    );

    demux_chan_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_chan_b (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (load_b),
        .i_data       (i_data),
        .i_ready      (i_B_ready),
        .o_data       (o_B_data),
        .o_valid      (o_B_valid),
        .o_count      (o_B_count),
        .o_can_accept (b_can_accept)
    );

endmodule

// File: tb/tb_demux32bit_1bitselect_buf.sv
// Directed bench for the 1-to-2 steering unit: a vector table for the
// cycle-by-cycle behaviour plus hand sequences for reset and counter wrap.
module tb_demux32bit_1bitselect_buf;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic        sel;
    logic        vld;
    logic        ardy;
    logic        brdy;

    logic        rdy;
    logic [31:0] a_data, b_data;
    logic        a_vld, b_vld;
    logic [15:0] a_cnt, b_cnt;

    logic        rdy4;
    logic [31:0] a_data4, b_data4;
    logic        a_vld4, b_vld4;
    logic [3:0]  a_cnt4, b_cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    demux32bit_1bitselect_buf u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_select  (sel),
        .i_valid   (vld),
        .o_ready   (rdy),
        .o_A_data  (a_data),
        .o_A_valid (a_vld),
        .i_A_ready (ardy),
        .o_B_data  (b_data),
        .o_B_valid (b_vld),
        .i_B_ready (brdy),
        .o_A_count (a_cnt),
        .o_B_count (b_cnt)
    );

    // Narrow-counter instance for the wrap check; shares all stimulus
    demux32bit_1bitselect_buf #(
        .DATA_W (32),
        .CNT_W  (4)
    ) u_dut4 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_select  (sel),
        .i_valid   (vld),
        .o_ready   (rdy4),
        .o_A_data  (a_data4),
        .o_A_valid (a_vld4),
        .i_A_ready (ardy),
        .o_B_data  (b_data4),
        .o_B_valid (b_vld4),
        .i_B_ready (brdy),
        .o_A_count (a_cnt4),
        .o_B_count (b_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        vld;
        logic [31:0] data;
        logic        ardy;
        logic        brdy;
        logic        exp_rdy;
        logic        exp_av;
        logic [31:0] exp_ad;
        logic        exp_bv;
        logic [31:0] exp_bd;
        logic [15:0] exp_ac;
        logic [15:0] exp_bc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic v, logic [31:0] d, logic ar, logic br,
                                logic er, logic eav, logic [31:0] ead, logic ebv,
                                logic [31:0] ebd, logic [15:0] eac, logic [15:0] ebc);
        vec_t t;
        t.sel = s;  t.vld = v;  t.data = d;  t.ardy = ar;  t.brdy = br;
        t.exp_rdy = er;  t.exp_av = eav;  t.exp_ad = ead;  t.exp_bv = ebv;
        t.exp_bd = ebd;  t.exp_ac = eac;  t.exp_bc = ebc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge
    task automatic drive(input logic s, input logic v, input logic [31:0] d,
                         input logic ar, input logic br);
        @(negedge clk);
        sel = s; vld = v; data = d; ardy = ar; brdy = br;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; data = '0; sel = 1'b0; vld = 1'b0; ardy = 1'b0; brdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset with both buffers full: outputs clear immediately
        drive(1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
        @(negedge clk);
        vld = 1'b0;
        #1;
        chk("pre_rst_a_valid", 64'(a_vld), 64'd1);
        chk("pre_rst_b_data", 64'(b_data), 64'h22);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_a_valid", 64'(a_vld), 64'd0);
        chk("rst_b_valid", 64'(b_vld), 64'd0);
        chk("rst_a_data", 64'(a_data), 64'd0);
        chk("rst_b_data", 64'(b_data), 64'd0);
        chk("rst_a_count", 64'(a_cnt), 64'd0);
        chk("rst_b_count", 64'(b_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b0;
        #1;
        chk("rst_ready_sel0", 64'(rdy), 64'd1);
        sel = 1'b1;
        #1;
        chk("rst_ready_sel1", 64'(rdy), 64'd1);

        // Vector table: expected o_ready before the edge, state after it
        // single steer
        vecs.push_back(mk(0, 1, 32'hDEADBEEF, 1, 1, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 0, 32'hDEADBEEF, 0, 0, 1, 0));
        // back-pressure on B, then load & drain on the same edge
        vecs.push_back(mk(1, 1, 32'h1, 1, 0, 1, 0, 32'hDEADBEEF, 1, 32'h1, 1, 0));
        vecs.push_back(mk(1, 1, 32'h2, 1, 0, 0, 0, 32'hDEADBEEF, 1, 32'h1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h2, 1, 0, 1, 0, 32'hDEADBEEF, 1, 32'h1, 1, 0));
        vecs.push_back(mk(1, 1, 32'h2, 1, 1, 1, 0, 32'hDEADBEEF, 1, 32'h2, 1, 1));
        vecs.push_back(mk(1, 0, 32'h0, 1, 1, 1, 0, 32'hDEADBEEF, 0, 32'h2, 1, 2));
        // streaming 0..7 alternating channels, both consumers ready
        vecs.push_back(mk(0, 1, 32'd0, 1, 1, 1, 1, 32'd0, 0, 32'd2, 1, 2));
        vecs.push_back(mk(1, 1, 32'd1, 1, 1, 1, 0, 32'd0, 1, 32'd1, 2, 2));
        vecs.push_back(mk(0, 1, 32'd2, 1, 1, 1, 1, 32'd2, 0, 32'd1, 2, 3));
        vecs.push_back(mk(1, 1, 32'd3, 1, 1, 1, 0, 32'd2, 1, 32'd3, 3, 3));
        vecs.push_back(mk(0, 1, 32'd4, 1, 1, 1, 1, 32'd4, 0, 32'd3, 3, 4));
        vecs.push_back(mk(1, 1, 32'd5, 1, 1, 1, 0, 32'd4, 1, 32'd5, 4, 4));
        vecs.push_back(mk(0, 1, 32'd6, 1, 1, 1, 1, 32'd6, 0, 32'd5, 4, 5));
        vecs.push_back(mk(1, 1, 32'd7, 1, 1, 1, 0, 32'd6, 1, 32'd7, 5, 5));
        vecs.push_back(mk(0, 0, 32'd0, 1, 1, 1, 0, 32'd6, 0, 32'd7, 5, 6));

        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].vld, vecs[i].data, vecs[i].ardy, vecs[i].brdy);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(rdy), 64'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_a_valid", i), 64'(a_vld), 64'(vecs[i].exp_av));
            chk($sformatf("v%0d_a_data", i), 64'(a_data), 64'(vecs[i].exp_ad));
            chk($sformatf("v%0d_b_valid", i), 64'(b_vld), 64'(vecs[i].exp_bv));
            chk($sformatf("v%0d_b_data", i), 64'(b_data), 64'(vecs[i].exp_bd));
            chk($sformatf("v%0d_a_count", i), 64'(a_cnt), 64'(vecs[i].exp_ac));
            chk($sformatf("v%0d_b_count", i), 64'(b_cnt), 64'(vecs[i].exp_bc));
        end

        // Counter wrap: 17 deliveries on A into a 4-bit counter
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drive(1'b0, 1'b1, 32'(k), 1'b1, 1'b1);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("wrap_cnt4_a", 64'(a_cnt4), 64'd1);
        chk("wrap_cnt16_a", 64'(a_cnt), 64'd17);
        chk("wrap_last_data", 64'(a_data), 64'd16);
        chk("wrap_b_count", 64'(b_cnt4), 64'd0);

        // Reset mid-operation with a word stuck in B
        do_reset();
        drive(1'b1, 1'b1, 32'hCAFE, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("mid_b_valid_before", 64'(b_vld), 64'd1);
        chk("mid_b_data_before", 64'(b_data), 64'hCAFE);
        chk("mid_ready_sel1_blocked", 64'(rdy), 64'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_b_valid_rst", 64'(b_vld), 64'd0);
        chk("mid_b_count_rst", 64'(b_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_b_valid_after", 64'(b_vld), 64'd0);
        chk("mid_b_count_after", 64'(b_cnt), 64'd0);
        chk("mid_b_data_after", 64'(b_data), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
